// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the core-to-bus memory bridge.
package mem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] FAULT_DATA_DEFAULT = 32'hDEADBEEF;

    // Bus transfers are word-sized; any nonzero low address bits are a fault.
    function automatic logic is_aligned(input logic [1:0] addr_lo);
        return addr_lo == 2'b00;
    endfunction

endpackage

// File: rtl/mem_bridge_if.sv
// Core-side request/response and external bus signals of the memory bridge.
interface mem_bridge_if;

    logic        mem_en;
    logic        mem_read;
    logic [31:0] addr;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic        ack;
    logic        err;

    logic        bus_valid;
    logic        bus_write;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    // The bridge itself: serves the core, masters the bus.
    modport slave (
        input  mem_en, mem_read, addr, data_out, bus_ready, bus_rdata,
        output data_in, ack, err, bus_valid, bus_write, bus_addr, bus_wdata
    );

    // The surrounding system: the requesting core plus the bus target.
    modport master (
        output mem_en, mem_read, addr, data_out, bus_ready, bus_rdata,
        input  data_in, ack, err, bus_valid, bus_write, bus_addr, bus_wdata
    );

endinterface

// File: rtl/mem_bridge_timer.sv
// Bus wait counter; expired flags the last cycle allowed before abort.
module mem_bridge_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    // Count stalled bus cycles; cleared whenever no bus request is active.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // A stall in this cycle would make the count reach TIMEOUT.
    assign expired = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bridge.sv
// Single-outstanding bridge from a core memory port to a ready/valid bus.
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT    = 255,
    parameter logic [31:0] FAULT_DATA = FAULT_DATA_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    mem_bridge_if.slave  mif
);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] data_in_q;
    logic        wr_q;
    logic        err_q;

    logic        latch_req;
    logic        addr_fault;
    logic        bus_done;
    logic        bus_fault;
    logic        timer_clr;
    logic        timer_en;
    logic        expired;

    mem_bridge_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clr),
        .enable  (timer_en),
        .expired (expired)
    );

    // Next-state and one-cycle action strobes; handshake beats timeout.
    always_comb begin
        state_d    = state_q;
        latch_req  = 1'b0;
        addr_fault = 1'b0;
        bus_done   = 1'b0;
        bus_fault  = 1'b0;
        timer_clr  = (state_q != BUS);
        timer_en   = (state_q == BUS) && !mif.bus_ready;
        case (state_q)
            IDLE: begin
                if (mif.mem_en) begin
                    if (is_aligned(mif.addr[1:0])) begin
                        latch_req = 1'b1;
                        state_d   = BUS;
                    end else begin
                        addr_fault = 1'b1;
                        state_d    = DONE;
                    end
                end
            end
            BUS: begin
                if (mif.bus_ready) begin
                    bus_done = 1'b1;
                    state_d  = DONE;
                end else if (expired) begin
                    bus_fault = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture and response data/error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            data_in_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (latch_req) begin
                addr_q  <= {mif.addr[31:2], 2'b00};
                wdata_q <= mif.data_out;
                wr_q    <= !mif.mem_read;
            end
            if (bus_done) begin
                err_q <= 1'b0;
                if (!wr_q) begin
                    data_in_q <= mif.bus_rdata;
                end
            end
            if (addr_fault || bus_fault) begin
                err_q     <= 1'b1;
                data_in_q <= FAULT_DATA;
            end
        end
    end

    assign mif.bus_valid = (state_q == BUS);
    assign mif.ack       = (state_q == DONE);
    assign mif.err       = err_q;
    assign mif.data_in   = data_in_q;
    assign mif.bus_addr  = addr_q;
    assign mif.bus_wdata = wdata_q;
    assign mif.bus_write = wr_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: directed cases then random transactions.
module tb_mem_bridge;

    localparam int unsigned TO    = 4;
    localparam logic [31:0] FAULT = 32'hDEADBEEF;

    logic clk;
    logic rst;

    mem_bridge_if mif ();

    mem_bridge #(
        .TIMEOUT (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mif (mif)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;

    // Reference view of data_in: what the core should currently see.
    logic [31:0] model_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction; bus target raises ready on bus cycle index ready_at.
    task automatic run_txn(input logic [31:0] a, input logic rd, input logic [31:0] wd,
                           input int unsigned ready_at, input logic [31:0] rdat,
                           input logic scramble);
        int unsigned exp_bus;
        int unsigned exp_lat;
        int unsigned cycles;
        int unsigned bus_n;
        logic        exp_err;
        logic        got_ack;
        if (a[1:0] != 2'b00) begin
            exp_err = 1'b1; exp_bus = 0; exp_lat = 1; model_data = FAULT;
        end else if (ready_at < TO) begin
            exp_err = 1'b0; exp_bus = ready_at + 1; exp_lat = ready_at + 2;
            if (rd) model_data = rdat;
        end else begin
            exp_err = 1'b1; exp_bus = TO; exp_lat = TO + 1; model_data = FAULT;
        end
        @(negedge clk);
        check("idle_valid", mif.bus_valid, 0);
        check("idle_ack", mif.ack, 0);
        mif.mem_en = 1'b1; mif.mem_read = rd; mif.addr = a; mif.data_out = wd;
        mif.bus_ready = 1'b0;
        cycles = 0; bus_n = 0; got_ack = 1'b0;
        while (!got_ack && cycles < 3 * TO + 10) begin
            @(negedge clk);
            cycles++;
            mif.bus_ready = 1'b0;
            mif.bus_rdata = $urandom;
            if (mif.bus_valid) begin
                check("bus_addr", mif.bus_addr, a);
                check("bus_write", mif.bus_write, !rd);
                check("bus_wdata", mif.bus_wdata, wd);
                if (bus_n == ready_at) begin
                    mif.bus_ready = 1'b1;
                    mif.bus_rdata = rdat;
                end
                bus_n++;
                if (scramble) begin
                    mif.addr = $urandom; mif.data_out = $urandom; mif.mem_read = 1'($urandom);
                end
            end
            if (mif.ack) begin
                got_ack = 1'b1;
                check("err", mif.err, exp_err);
                check("data_in", mif.data_in, model_data);
                check("latency", cycles, exp_lat);
                check("bus_cycles", bus_n, exp_bus);
                mif.mem_en = 1'b0;
            end
        end
        check("ack_seen", got_ack, 1);
    endtask

    int unsigned cycles;
    int unsigned acks;
    int unsigned bus_starts;
    int unsigned ack_at [2];
    logic        prev_valid;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] ra;

    initial begin
        mif.mem_en = 1'b1; mif.mem_read = 1'b1; mif.addr = 32'h100; mif.data_out = '0;
        mif.bus_ready = 1'b1; mif.bus_rdata = '0;
        model_data = '0;
        rst = 1'b1;

        // Reset state, with a request pending to show reset dominates.
        repeat (3) @(negedge clk);
        check("rst_valid", mif.bus_valid, 0);
        check("rst_ack", mif.ack, 0);
        check("rst_err", mif.err, 0);
        check("rst_write", mif.bus_write, 0);
        check("rst_data_in", mif.data_in, 0);
        check("rst_addr", mif.bus_addr, 0);
        check("rst_wdata", mif.bus_wdata, 0);
        rst = 1'b0; mif.mem_en = 1'b0; mif.bus_ready = 1'b0;

        // Minimum-latency load.
        run_txn(32'h100, 1'b1, 32'h0, 0, 32'h12345678, 1'b0);
        // Store with three wait cycles while core inputs churn.
        run_txn(32'h204, 1'b0, 32'hCAFEF00D, 3, 32'h0BADF00D, 1'b1);
        // Misaligned load.
        run_txn(32'h103, 1'b1, 32'h0, 0, 32'h11111111, 1'b0);
        // Timeout, then ready on the last permitted cycle.
        run_txn(32'h500, 1'b1, 32'h0, 100, 32'h22222222, 1'b0);
        run_txn(32'h504, 1'b1, 32'h0, TO - 1, 32'h33333333, 1'b0);

        // Reset on the second stalled bus cycle abandons the request.
        @(negedge clk);
        mif.mem_en = 1'b1; mif.mem_read = 1'b1; mif.addr = 32'h300; mif.bus_ready = 1'b0;
        @(negedge clk);
        check("mid_bus0", mif.bus_valid, 1);
        @(negedge clk);
        check("mid_bus1", mif.bus_valid, 1);
        rst = 1'b1; mif.mem_en = 1'b0;
        @(negedge clk);
        check("mid_valid", mif.bus_valid, 0);
        check("mid_ack", mif.ack, 0);
        check("mid_data_in", mif.data_in, 0);
        rst = 1'b0; model_data = '0;
        @(negedge clk);
        check("mid_ack_after", mif.ack, 0);
        run_txn(32'h304, 1'b1, 32'h0, 1, 32'h44444444, 1'b0);

        // Back-to-back loads with mem_en held high throughout.
        rd1 = $urandom; rd2 = $urandom;
        @(negedge clk);
        mif.mem_en = 1'b1; mif.mem_read = 1'b1; mif.addr = 32'h400; mif.bus_ready = 1'b0;
        cycles = 0; acks = 0; bus_starts = 0; prev_valid = 1'b0;
        ack_at[0] = 0; ack_at[1] = 0;
        while (acks < 2 && cycles < 30) begin
            @(negedge clk);
            cycles++;
            mif.bus_ready = 1'b0;
            if (mif.bus_valid) begin
                if (!prev_valid) bus_starts++;
                check("b2b_addr", mif.bus_addr, (acks == 0) ? 32'h400 : 32'h800);
                mif.bus_ready = 1'b1;
                mif.bus_rdata = (acks == 0) ? rd1 : rd2;
            end
            prev_valid = mif.bus_valid;
            if (mif.ack) begin
                ack_at[acks] = cycles;
                check("b2b_data", mif.data_in, (acks == 0) ? rd1 : rd2);
                acks++;
                mif.addr = 32'h800;
                if (acks == 2) mif.mem_en = 1'b0;
            end
        end
        model_data = rd2;
        check("b2b_acks", acks, 2);
        check("b2b_bus_txns", bus_starts, 2);
        check("b2b_ack1_cycle", ack_at[0], 2);
        check("b2b_ack2_cycle", ack_at[1], 5);

        // Random transactions against the reference model.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom & 32'h0000_FFFF;
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            run_txn(ra, 1'($urandom), $urandom, $urandom_range(0, TO + 1), $urandom,
                    1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
